// File: rtl/memory_cycle_stall_pkg.sv
// Shared types and constants for the memory stage: FSM encoding,
// default datapath width and the control bubble written into M/W.
package memory_cycle_stall_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Control fields of the W bundle that a bubble forces; data fields hold.
  typedef struct packed {
    logic reg_write;
    logic err;
  } w_ctrl_t;

  localparam w_ctrl_t W_CTRL_BUBBLE = '{reg_write: 1'b0, err: 1'b0};

endpackage

// File: rtl/memory_cycle_stall_wait_counter.sv
// Wait-cycle counter for an outstanding data-memory access. Cleared when an
// access enters WAIT, incremented each further WAIT cycle; flags the last
// permitted cycle so the stage can declare a timeout.
module mem_wait_counter #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/memory_cycle_stall.sv
// Memory stage: drives the valid/ack data bus, stalls the pipeline while an
// access is outstanding, flags timeouts and misaligned accesses, and
// registers the M/W boundary.
module memory_cycle_stall #(
  parameter int XLEN     = memory_cycle_stall_pkg::XLEN,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            ResultSrcM,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ALU_ResultM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            StallM,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic            ErrW
);

  import memory_cycle_stall_pkg::*;

  state_e           state_q, state_d;
  logic             memop_s, misaligned_s, req_s, ack_s;
  logic             timeout_s, done_s, stall_s, fault_s;
  logic             cnt_clr_s, cnt_inc_s, at_limit_s;
  logic [CNT_W-1:0] cnt_s;

  logic             reg_write_q, result_src_q, err_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  pc_plus4_q, alu_result_q, read_data_q;

  // Request is gated by reset so an aborted access drops off the bus at once;
  // acks are only honoured while a request is up.
  assign memop_s      = MemWriteM | ResultSrcM;
  assign misaligned_s = memop_s & (ALU_ResultM[1:0] != 2'b00);
  assign req_s        = memop_s & ~misaligned_s & rst;
  assign ack_s        = dmem_ack & req_s;
  assign timeout_s    = (state_q == ST_WAIT) & at_limit_s & ~ack_s;
  assign done_s       = ack_s | timeout_s;
  assign stall_s      = req_s & ~done_s;
  assign fault_s      = misaligned_s | timeout_s;

  assign dmem_req   = req_s;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALU_ResultM;
  assign dmem_wdata = WriteDataM;
  assign StallM     = stall_s;

  mem_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr_s),
    .inc_i      (cnt_inc_s),
    .cnt_o      (cnt_s),
    .at_limit_o (at_limit_s)
  );

  // Next-state logic: enter WAIT on an unacknowledged request, leave on ack or timeout.
  always_comb begin
    state_d   = state_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s & ~ack_s) begin
          state_d   = ST_WAIT;
          cnt_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ack_s) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // M/W boundary: bubble while stalled, capture on completion, flag faults.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'd0;
      pc_plus4_q   <= {XLEN{1'b0}};
      alu_result_q <= {XLEN{1'b0}};
      read_data_q  <= {XLEN{1'b0}};
      err_q        <= 1'b0;
    end else if (stall_s) begin
      reg_write_q <= W_CTRL_BUBBLE.reg_write;
      err_q       <= W_CTRL_BUBBLE.err;
    end else begin
      result_src_q <= ResultSrcM;
      rd_q         <= RD_M;
      pc_plus4_q   <= PCPlus4M;
      alu_result_q <= ALU_ResultM;
      if (fault_s) begin
        reg_write_q <= 1'b0;
        read_data_q <= {XLEN{1'b0}};
        err_q       <= 1'b1;
      end else begin
        reg_write_q <= RegWriteM;
        read_data_q <= (ResultSrcM & ack_s) ? dmem_rdata : {XLEN{1'b0}};
        err_q       <= 1'b0;
      end
    end
  end

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pc_plus4_q;
  assign ALU_ResultW = alu_result_q;
  assign ReadDataW   = read_data_q;
  assign ErrW        = err_q;

  logic unused_s;
  assign unused_s = ^cnt_s;

endmodule

// File: tb/tb_memory_cycle_stall.sv
// Self-checking bench for memory_cycle_stall. A transaction-level model
// predicts how many stall cycles each access takes and what the W bundle
// holds after it completes.
module tb_memory_cycle_stall;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
  logic [4:0]  RD_M = 5'd0;
  logic [31:0] PCPlus4M = 32'd0, WriteDataM = 32'd0, ALU_ResultM = 32'd0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        StallM, RegWriteW, ResultSrcW, ErrW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Model of the last completed W bundle.
  logic        m_rw, m_rs, m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_alu, m_rdata;

  memory_cycle_stall #(.XLEN(32), .MAX_WAIT(MW), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .ErrW(ErrW)
  );

  always #5 clk = ~clk;

  task automatic drive_m(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; ALU_ResultM = addr; WriteDataM = wd;
  endtask

  // One instruction through M. delay = cycle index of the ack (0 = same cycle), <0 = never.
  task automatic do_txn(input string name, input logic rw, input logic mw, input logic rs,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdv, input int delay);
    bit memop, mis, req, tmo;
    int e;
    logic [103:0] exp_w, got_w;
    memop = mw | rs;
    mis   = memop && (addr[1:0] != 2'b00);
    req   = memop && !mis;
    tmo   = req && (delay < 0 || delay > MW);
    e     = !req ? 0 : (tmo ? MW : delay);
    for (int k = 0; k <= e; k++) begin
      @(negedge clk);
      drive_m(rw, mw, rs, rd, pc, addr, wd);
      dmem_ack   = req ? (k == delay) : 1'($urandom_range(0, 1));
      dmem_rdata = (req && k == delay) ? rdv : $urandom;
      #1;
      tot_cnt++;
      if (StallM !== (k < e)) $display("FAIL %s stall k=%0d got %b exp %b", name, k, StallM, (k < e));
      else pass_cnt++;
      tot_cnt++;
      if (dmem_req !== req) $display("FAIL %s req k=%0d got %b exp %b", name, k, dmem_req, req);
      else pass_cnt++;
      if (req) begin
        tot_cnt++;
        if ({dmem_we, dmem_addr, dmem_wdata} !== {mw, addr, wd})
          $display("FAIL %s bus k=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                   name, k, dmem_we, dmem_addr, dmem_wdata, mw, addr, wd);
        else pass_cnt++;
      end
      @(posedge clk); #1;
      if (k < e) begin
        tot_cnt++;
        if ({RegWriteW, ErrW, RD_W, ALU_ResultW} !== {1'b0, 1'b0, m_rd, m_alu})
          $display("FAIL %s bubble k=%0d got rw=%b err=%b rd=%0d alu=%h exp rw=0 err=0 rd=%0d alu=%h",
                   name, k, RegWriteW, ErrW, RD_W, ALU_ResultW, m_rd, m_alu);
        else pass_cnt++;
      end
    end
    m_err   = mis || tmo;
    m_rw    = m_err ? 1'b0 : rw;
    m_rs    = rs;
    m_rd    = rd;
    m_pc    = pc;
    m_alu   = addr;
    m_rdata = (!m_err && rs && req) ? rdv : 32'd0;
    exp_w = {m_rw, m_rs, m_err, m_rd, m_pc, m_alu, m_rdata};
    got_w = {RegWriteW, ResultSrcW, ErrW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW};
    tot_cnt++;
    if (got_w !== exp_w)
      $display("FAIL %s wb got rw=%b rs=%b err=%b rd=%0d pc=%h alu=%h rdata=%h exp rw=%b rs=%b err=%b rd=%0d pc=%h alu=%h rdata=%h",
               name, RegWriteW, ResultSrcW, ErrW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW,
               m_rw, m_rs, m_err, m_rd, m_pc, m_alu, m_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_m(1'b1, 1'b0, 1'b1, 5'd7, 32'h40, 32'h100, 32'h0);
    dmem_ack = 1'b0;
    #1;
    tot_cnt++;
    if ({dmem_req, StallM} !== 2'b00) $display("FAIL reset_gate got req=%b stall=%b exp 0 0", dmem_req, StallM);
    else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++;
    if ({RegWriteW, ResultSrcW, ErrW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0)
      $display("FAIL reset_w got rw=%b rs=%b err=%b rd=%0d pc=%h alu=%h rdata=%h exp all 0",
               RegWriteW, ResultSrcW, ErrW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    m_rw = 1'b0; m_rs = 1'b0; m_err = 1'b0; m_rd = 5'd0; m_pc = 32'd0; m_alu = 32'd0; m_rdata = 32'd0;
  endtask

  task automatic test_alu();
    do_txn("alu", 1'b1, 1'b0, 1'b0, 5'd5, 32'h8, 32'h1234, 32'h55, 32'h0, 0);
  endtask

  task automatic test_zero_wait_load();
    do_txn("load0", 1'b1, 1'b0, 1'b1, 5'd9, 32'hC, 32'h100, 32'h0, 32'hDEADBEEF, 0);
  endtask

  task automatic test_load_wait3();
    do_txn("load3", 1'b1, 1'b0, 1'b1, 5'd10, 32'h10, 32'h104, 32'h0, 32'h0BADF00D, 3);
  endtask

  task automatic test_store();
    do_txn("store", 1'b0, 1'b1, 1'b0, 5'd0, 32'h14, 32'h200, 32'hCAFE, 32'h0, 1);
  endtask

  task automatic test_timeout_misaligned();
    do_txn("timeout", 1'b1, 1'b0, 1'b1, 5'd11, 32'h18, 32'h300, 32'h0, 32'h1111, -1);
    do_txn("misalign", 1'b1, 1'b0, 1'b1, 5'd12, 32'h1C, 32'h102, 32'h0, 32'h2222, 0);
    do_txn("after_err", 1'b1, 1'b0, 1'b0, 5'd13, 32'h20, 32'h77, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset_in_wait();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_m(1'b1, 1'b0, 1'b1, 5'd14, 32'h24, 32'h400, 32'h0);
      dmem_ack = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tot_cnt++;
    if ({dmem_req, StallM} !== 2'b00) $display("FAIL rst_wait_gate got req=%b stall=%b exp 0 0", dmem_req, StallM);
    else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++;
    if ({RegWriteW, ResultSrcW, ErrW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 104'd0)
      $display("FAIL rst_wait_w got rw=%b rs=%b err=%b rd=%0d pc=%h alu=%h rdata=%h exp all 0",
               RegWriteW, ResultSrcW, ErrW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    drive_m(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFEEDFACE;
    #1;
    tot_cnt++;
    if ({dmem_req, StallM} !== 2'b00) $display("FAIL late_ack_bus got req=%b stall=%b exp 0 0", dmem_req, StallM);
    else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++;
    if ({RegWriteW, ErrW, ReadDataW} !== 34'd0)
      $display("FAIL late_ack_w got rw=%b err=%b rdata=%h exp 0 0 0", RegWriteW, ErrW, ReadDataW);
    else pass_cnt++;
    m_rw = 1'b0; m_rs = 1'b0; m_err = 1'b0; m_rd = 5'd0; m_pc = 32'd0; m_alu = 32'd0; m_rdata = 32'd0;
    do_txn("post_rst_load", 1'b1, 1'b0, 1'b1, 5'd15, 32'h28, 32'h500, 32'h0, 32'h3333, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind, dly;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      dly = $urandom_range(0, MW + 2);
      if (dly == MW + 2) dly = -1;
      do_txn("rand", 1'($urandom_range(0, 1)), kind == 2, kind == 1, 5'($urandom),
             $urandom, a, $urandom, $urandom, dly);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_zero_wait_load();
    test_load_wait3();
    test_store();
    test_timeout_misaligned();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
